apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB completer that terminates the bus driven by the team's APB master wrapper: 8-bit address, 9-bit data. It holds a bank of DEPTH read/write 9-bit registers plus a read-only write-counter at address 0xFF. It inserts a fixed number of wait states per transfer and flags illegal accesses with pslverr. It sits on the peripheral side of the processor's APB link, and every processor load/store to the peripheral space completes here.

## Interface
- DEPTH, 16: number of R/W registers, addresses 0..DEPTH-1; legal range 1..255.
- WAIT_CYCLES, 1: wait states inserted before pready; legal range 0..7.

One clock; reset is asynchronous and active-high.
- clk  in  1  APB clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- paddr  in  8  transfer address.
- psel  in  1  completer select.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  9  write data.
- prdata  out  9  read data; valid only while pready=1 on a read, otherwise 0.
- pready  out  1  transfer-complete strobe.
- pslverr  out  1  error response; valid only while pready=1, otherwise 0.

## Operation
- FSM states:
  - IDLE: waiting for a setup phase.
  - ACCESS: transfer latched, counting wait states.
- IDLE → ACCESS on an edge with psel=1 and penable=0. On that edge:
  - latch paddr into addr_q, pwrite into wr_q, pwdata into wdata_q;
  - load the wait counter cnt with WAIT_CYCLES.
- In IDLE, psel=1 with penable=1 (no prior setup) is ignored. The FSM stays in IDLE and pready stays 0.
- ACCESS with cnt != 0 and psel=1: cnt decrements and pready=0.
- ACCESS with cnt == 0: pready=1, decoded from registered state. This is the completion cycle, and the FSM returns to IDLE on the next edge.
- ACCESS with psel=0 on any edge: abort to IDLE. No write, no counter increment, no pready.
- Legality of the latched address:
  - addr_q < DEPTH: register access.
  - addr_q == 0xFF and read: counter access.
  - Any other address, or a write to 0xFF: illegal.
- Completion cycle, legal write: mem[addr_q] ← wdata_q on the closing edge, and wr_cnt increments.
- Completion cycle, legal read: prdata = mem[addr_q], or wr_cnt when addr_q = 0xFF.
- Completion cycle, illegal access: pslverr=1, prdata=0, no state change to mem or wr_cnt.
- wr_cnt is 9 bits and counts completed legal writes only. It wraps 511 → 0.
- Address, direction and data come from the setup-phase latch. Changes on paddr, pwrite or pwdata during ACCESS have no effect.
- Read-after-write to the same address in the next transfer returns the new data.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, all mem entries = 0, wr_cnt = 0;
  - prdata = 0, pready = 0, pslverr = 0.
- Reset asserted mid-transfer: immediate return to reset values, and the pending write is discarded.
- Transfer length from the setup cycle T0:
  - pready is high in cycle T0+1+WAIT_CYCLES;
  - with WAIT_CYCLES=0, pready is high in T0+1 (standard 2-cycle APB transfer).
- pready, pslverr and prdata are decoded only from registered state and latched data. They have no combinational path from APB inputs.
- Write data becomes visible to a read whose completion cycle is at or after the write's closing edge plus one cycle.
- Back-to-back transfers: a setup phase in the cycle immediately after completion is accepted. Sustained throughput is one transfer per 2+WAIT_CYCLES cycles.
- pready is high for exactly one cycle per transfer.

## Test plan
- Reset, then write 9'h1A5 to 0x03 and read 0x03 (DEPTH=16, WAIT_CYCLES=1):
  - both transfers see pready in T0+2;
  - the read returns prdata=9'h1A5, pslverr=0.
- WAIT_CYCLES=0, back-to-back writes to 0x00..0x0F with data = 0x100+addr, then read 0xFF:
  - each pready lands in T0+1;
  - the 0xFF read returns 9'h010.
- Write 0x10 (out of range) and write 0xFF:
  - both complete with pslverr=1;
  - wr_cnt unchanged, and a read of 0x00 still returns its old value.
- Drop psel in the wait cycle of a write to 0x05 (WAIT_CYCLES=3):
  - no pready;
  - a subsequent read of 0x05 returns 0 and wr_cnt is unchanged.
- Assert rst during the ACCESS phase of a write to 0x02 with data 9'h0FF:
  - all outputs read 0 immediately;
  - after release, a read of 0x02 returns 0 and a read of 0xFF returns 0.
- Perform 512 legal writes, then read 0xFF:
  - the read returns 0 (wrap);
  - one more write, then a read of 0xFF returns 1.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with R/W register bank, write counter and wait states
module apb_slave_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] paddr,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [8:0] pwdata,
    output logic [8:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
    localparam logic [7:0] CNT_ADDR  = 8'hFF;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [7:0]    addr_q;
    logic          wr_q;
    logic [8:0]    wdata_q;
    logic [8:0]    wr_cnt;
    logic [8:0]    mem [DEPTH];

    logic          reg_hit;
    logic          cnt_hit;
    logic          done;
    logic [AW-1:0] idx;

    // Decode of the latched transfer; the counter is only reachable by reads
    assign idx     = addr_q[AW-1:0];
    assign reg_hit = (int'(addr_q) < DEPTH);
    assign cnt_hit = (addr_q == CNT_ADDR) && !wr_q;
    assign done    = (state == ACCESS) && (cnt == 3'd0);

    // Response is a pure function of registered state, so no APB input reaches pready/prdata/pslverr
    always_comb begin
        pready  = done;
        pslverr = done && !(reg_hit || cnt_hit);
        prdata  = '0;
        if (done && !wr_q && reg_hit) begin
            prdata = mem[idx];
        end else if (done && cnt_hit) begin
            prdata = wr_cnt;
        end
    end

    // Transfer FSM: latch on setup, count wait states, commit legal writes on the closing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wr_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // An access phase without a preceding setup is ignored
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        wr_q    <= pwrite;
                        wdata_q <= pwdata;
                        cnt     <= WAIT_INIT;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Master abandoned the transfer: nothing is committed
                        state <= IDLE;
                    end else if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        if (wr_q && reg_hit) begin
                            mem[idx] <= wdata_q;
                            wr_cnt   <= wr_cnt + 9'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - scoreboard and vector-table bench for apb_slave_regfile
module tb_apb_slave_regfile;

    logic       clk;
    logic       rst;
    logic [7:0] paddr;
    logic [2:0] psel_v;
    logic       penable;
    logic       pwrite;
    logic [8:0] pwdata;
    logic [8:0] prd  [3];
    logic       rdy  [3];
    logic       perr [3];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic       w;
        logic [8:0] d;
        logic [8:0] er;
        logic       ee;
        bit         scr;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[14];

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prd[0]), .pready(rdy[0]), .pslverr(perr[0])
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prd[1]), .pready(rdy[1]), .pslverr(perr[1])
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prd[2]), .pready(rdy[2]), .pslverr(perr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic int waits_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name, input int k);
        chk(name, {22'b0, rdy[k], perr[k], prd[k]}, 32'h0);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        psel_v  = '0;
        penable = 1'b0;
    endtask

    // One complete transfer on instance k; expectation is queued at drive time, compared at pready
    task automatic xfer(input int k, input logic [7:0] a, input logic w, input logic [8:0] d,
                        input logic [8:0] er, input logic ee, input bit scr);
        exp_t e;
        int   n;
        bit   got;
        e.rdata = er;
        e.err   = ee;
        e.lat   = 1 + waits_of(k);
        sbq.push_back(e);
        @(posedge clk); #1;
        psel_v  = 3'b001 << k;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        @(negedge clk);
        chk_quiet("setup_cycle_outputs_low", k);
        @(posedge clk); #1;
        penable = 1'b1;
        if (scr) begin
            paddr  = ~a;
            pwrite = ~w;
            pwdata = ~d;
        end
        n   = 1;
        got = 1'b0;
        while (!got && n <= 20) begin
            @(negedge clk);
            if (rdy[k]) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        e = sbq.pop_front();
        chk("pready_seen", {31'b0, got}, 32'd1);
        chk("latency", n, e.lat);
        chk("prdata", {23'b0, prd[k]}, {23'b0, e.rdata});
        chk("pslverr", {31'b0, perr[k]}, {31'b0, e.err});
    endtask

    initial begin
        tbl[0]  = '{8'h03, 1'b1, 9'h1A5, 9'h000, 1'b0, 1'b0};
        tbl[1]  = '{8'h03, 1'b0, 9'h000, 9'h1A5, 1'b0, 1'b0};
        tbl[2]  = '{8'h00, 1'b1, 9'h055, 9'h000, 1'b0, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 9'h000, 9'h055, 1'b0, 1'b0};
        tbl[4]  = '{8'h10, 1'b1, 9'h0AA, 9'h000, 1'b1, 1'b0};
        tbl[5]  = '{8'hFF, 1'b1, 9'h001, 9'h000, 1'b1, 1'b0};
        tbl[6]  = '{8'hFF, 1'b0, 9'h000, 9'h002, 1'b0, 1'b0};
        tbl[7]  = '{8'h00, 1'b0, 9'h000, 9'h055, 1'b0, 1'b0};
        tbl[8]  = '{8'h10, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0};
        tbl[9]  = '{8'h0F, 1'b1, 9'h1FF, 9'h000, 1'b0, 1'b0};
        tbl[10] = '{8'h0F, 1'b0, 9'h000, 9'h1FF, 1'b0, 1'b0};
        tbl[11] = '{8'h07, 1'b1, 9'h0AB, 9'h000, 1'b0, 1'b1};
        tbl[12] = '{8'h07, 1'b0, 9'h000, 9'h0AB, 1'b0, 1'b1};
        tbl[13] = '{8'hFF, 1'b0, 9'h000, 9'h004, 1'b0, 1'b0};

        rst     = 1'b1;
        psel_v  = '0;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_quiet("reset_outputs", k);
        rst = 1'b0;

        // Access phase with no setup must be ignored
        @(posedge clk); #1;
        psel_v  = 3'b001;
        penable = 1'b1;
        paddr   = 8'h03;
        pwrite  = 1'b1;
        pwdata  = 9'h0EE;
        repeat (3) @(negedge clk);
        chk_quiet("no_setup_ignored", 0);
        go_idle();

        // Vector table on WAIT_CYCLES=1 instance
        for (int i = 0; i < 14; i++) begin
            xfer(0, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].er, tbl[i].ee, tbl[i].scr);
        end
        go_idle();

        // WAIT_CYCLES=0: back-to-back sweep, then counter wrap
        for (int a = 0; a < 16; a++) begin
            xfer(1, 8'(a), 1'b1, 9'(9'h100 + a), 9'h000, 1'b0, 1'b0);
        end
        xfer(1, 8'hFF, 1'b0, 9'h000, 9'h010, 1'b0, 1'b0);
        xfer(1, 8'h05, 1'b0, 9'h000, 9'h105, 1'b0, 1'b0);
        for (int i = 0; i < 496; i++) begin
            xfer(1, 8'(i % 16), 1'b1, 9'(i), 9'h000, 1'b0, 1'b0);
        end
        xfer(1, 8'hFF, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0);
        xfer(1, 8'h02, 1'b1, 9'h033, 9'h000, 1'b0, 1'b0);
        xfer(1, 8'hFF, 1'b0, 9'h000, 9'h001, 1'b0, 1'b0);
        go_idle();

        // WAIT_CYCLES=3: abort a write by dropping psel in a wait cycle
        xfer(2, 8'h01, 1'b1, 9'h011, 9'h000, 1'b0, 1'b0);
        go_idle();
        @(posedge clk); #1;
        psel_v  = 3'b100;
        penable = 1'b0;
        paddr   = 8'h05;
        pwrite  = 1'b1;
        pwdata  = 9'h123;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk_quiet("abort_wait1", 2);
        @(posedge clk); #1;
        psel_v  = '0;
        penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_quiet("abort_no_pready", 2);
        end
        xfer(2, 8'h05, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0);
        xfer(2, 8'hFF, 1'b0, 9'h000, 9'h001, 1'b0, 1'b0);
        go_idle();

        // Reset in the completion cycle of a write discards it
        @(posedge clk); #1;
        psel_v  = 3'b001;
        penable = 1'b0;
        paddr   = 8'h02;
        pwrite  = 1'b1;
        pwdata  = 9'h0FF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_pready", {31'b0, rdy[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk_quiet("async_reset_outputs", 0);
        @(posedge clk); #1;
        psel_v  = '0;
        penable = 1'b0;
        rst     = 1'b0;
        xfer(0, 8'h02, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0);
        xfer(0, 8'hFF, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0);
        go_idle();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
